// File: rtl/spi_word_slave.sv
// spi_word_slave
//   SPI slave that moves one WIDTH-bit word per SPI word time. SCK, SS and
//   MOSI arrive asynchronously and are synchronised into the clk domain.
//   Edges are then detected, so SCK must be several clk periods per half
//   cycle. A single-entry holding register feeds the tx shift register. When
//   nothing is queued at a load point, IDLE_WORD is sent instead.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   SCK, SS      SPI clock and active-low select from the master (async)
//   MOSI, MISO   serial data in / out
//   tx_data      word to transmit, accepted when tx_valid && tx_ready
//   tx_valid     tx_data is valid
//   tx_ready     holding register empty; a word can be accepted
//   rx_data      last complete received word
//   rx_valid     one-clk pulse when rx_data is updated
//   tx_underrun  one-clk pulse when IDLE_WORD was loaded for lack of data
//   frame_abort  one-clk pulse when SS was released mid-word
//   busy         slave is selected (synchronised SS active)
module spi_word_slave #(
  parameter int               WIDTH     = 8,
  parameter logic             CPOL      = 1'b0,
  parameter logic             CPHA      = 1'b0,
  parameter logic             MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [2:0]       sck_sync;
  logic [2:0]       ss_sync;
  logic [1:0]       mosi_sync;
  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic             load_pending;
  logic             primed;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] holding;
  logic             holding_full;

  logic             active;
  logic             sck_rise, sck_fall, leading, trailing;
  logic             ss_fall, ss_rise, frame_start;
  logic             sample_edge, shift_edge, hold_edge, load_event;
  logic [WIDTH-1:0] rx_next, tx_shifted;

  // Synchronisers preset to the idle line levels so that leaving reset
  // cannot look like an SCK or SS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= {3{CPOL}};
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      ss_sync   <= {ss_sync[1:0], SS};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign active      = (state == ST_ACTIVE);
  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign leading     = CPOL ? sck_fall : sck_rise;
  assign trailing    = CPOL ? sck_rise : sck_fall;
  assign ss_fall     = ss_sync[2] & ~ss_sync[1];
  assign ss_rise     = ~ss_sync[2] & ss_sync[1];
  assign frame_start = !active && ss_fall;

  // SCK activity only counts while selected; an edge arriving in the same
  // cycle as deselection belongs to no word.
  assign sample_edge = active && !ss_rise && (CPHA ? trailing : leading);
  assign shift_edge  = active && !ss_rise && (CPHA ? leading : trailing);

  // With CPHA=1 the frame-start load already supplied word 0, so the first
  // shift edge of the frame neither reloads nor shifts; it is that word's load.
  assign hold_edge  = CPHA && primed && shift_edge;
  assign load_event = frame_start ||
                      (CPHA ? (shift_edge && (bit_cnt == '0) && !primed)
                            : (shift_edge && load_pending));

  assign rx_next    = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_sync[1]}
                                : {mosi_sync[1], rx_shift[WIDTH-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0}
                                : {1'b0, tx_shift[WIDTH-1:1]};

  // Frame control: state, bit counter, and the flags that place tx loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      primed       <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (frame_start) begin
        state        <= ST_ACTIVE;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        primed       <= 1'b1;
      end else if (active && ss_rise) begin
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        primed       <= 1'b0;
        frame_abort  <= (bit_cnt != '0);
      end else begin
        if (sample_edge) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt      <= '0;
            load_pending <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (shift_edge) begin
          load_pending <= 1'b0;
          primed       <= 1'b0;
        end
      end
    end
  end

  // Receive path: rx_data and rx_valid update together, one clk after the
  // final sample edge has been detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_edge) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load_event) begin
        if (holding_full) begin
          tx_shift <= holding;
        end else begin
          tx_shift    <= IDLE_WORD;
          tx_underrun <= 1'b1;
        end
      end else if (shift_edge && !hold_edge) begin
        tx_shift <= tx_shifted;
      end
    end
  end

  // Holding register. Acceptance needs it empty and emptying needs it full,
  // so a handshake coinciding with a load leaves the new word held while the
  // load falls back to IDLE_WORD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding      <= '0;
      holding_full <= 1'b0;
    end else begin
      if (load_event && holding_full) begin
        holding_full <= 1'b0;
      end
      if (tx_valid && !holding_full) begin
        holding      <= tx_data;
        holding_full <= 1'b1;
      end
    end
  end

  assign MISO     = active ? (MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0]) : 1'b0;
  assign tx_ready = !holding_full;
  assign busy     = active;

endmodule

// File: tb/tb_spi_word_slave.sv
// tb_spi_word_slave
//   Drives three spi_word_slave configurations with a bit-banged SPI master:
//     d=0: WIDTH=8,  mode 0, MSB first, IDLE_WORD=0xFF
//     d=1: WIDTH=8,  mode 3, MSB first, IDLE_WORD=0xFF
//     d=2: WIDTH=16, mode 0, LSB first, IDLE_WORD=0
//   Expected MISO words and underrun counts come from a word-level model of
//   the single-entry holding register and the points at which loads happen.
module tb_spi_word_slave;

  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sck, ss, mosi, txv;
  logic [7:0] txd0, txd1, rxd0, rxd1;
  logic [15:0] txd2, rxd2;
  logic miso0, miso1, miso2, txr0, txr1, txr2, rxv0, rxv1, rxv2;
  logic und0, und1, und2, abt0, abt1, abt2, bsy0, bsy1, bsy2;

  spi_word_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .IDLE_WORD(8'hFF)) u0 (
    .clk(clk), .rst(rst), .SCK(sck[0]), .SS(ss[0]), .MOSI(mosi[0]), .MISO(miso0),
    .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_underrun(und0), .frame_abort(abt0), .busy(bsy0));

  spi_word_slave #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .IDLE_WORD(8'hFF)) u1 (
    .clk(clk), .rst(rst), .SCK(sck[1]), .SS(ss[1]), .MOSI(mosi[1]), .MISO(miso1),
    .tx_data(txd1), .tx_valid(txv[1]), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1),
    .tx_underrun(und1), .frame_abort(abt1), .busy(bsy1));

  spi_word_slave #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .IDLE_WORD(16'h0000)) u2 (
    .clk(clk), .rst(rst), .SCK(sck[2]), .SS(ss[2]), .MOSI(mosi[2]), .MISO(miso2),
    .tx_data(txd2), .tx_valid(txv[2]), .tx_ready(txr2), .rx_data(rxd2), .rx_valid(rxv2),
    .tx_underrun(und2), .frame_abort(abt2), .busy(bsy2));

  // Pulse counters, sampled by the stimulus as before/after differences.
  int rxv_n[3] = '{0, 0, 0};
  int und_n[3] = '{0, 0, 0};
  int abt_n[3] = '{0, 0, 0};
  always @(posedge clk) begin
    if (rxv0) rxv_n[0] <= rxv_n[0] + 1;
    if (rxv1) rxv_n[1] <= rxv_n[1] + 1;
    if (rxv2) rxv_n[2] <= rxv_n[2] + 1;
    if (und0) und_n[0] <= und_n[0] + 1;
    if (und1) und_n[1] <= und_n[1] + 1;
    if (und2) und_n[2] <= und_n[2] + 1;
    if (abt0) abt_n[0] <= abt_n[0] + 1;
    if (abt1) abt_n[1] <= abt_n[1] + 1;
    if (abt2) abt_n[2] <= abt_n[2] + 1;
  end

  int checks;
  int failures;

  // Word-level model: one holding slot per slave plus an underrun tally.
  logic [31:0] mq_word[3];
  logic        mq_full[3];
  int          m_und[3];

  logic [31:0] mw[4];
  logic [31:0] gw[4];
  logic [31:0] em[4];
  int s_rxv, s_und, s_abt, s_mund;

  function automatic int w_of(input int d);
    return (d == 2) ? 16 : 8;
  endfunction
  function automatic bit cpha_of(input int d);
    return (d == 1);
  endfunction
  function automatic bit msb_of(input int d);
    return (d != 2);
  endfunction
  function automatic logic [31:0] mask_of(input int d);
    return (d == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction
  function automatic logic [31:0] idle_of(input int d);
    return (d == 2) ? 32'h0 : 32'hFF;
  endfunction

  function automatic logic miso_of(input int d);
    case (d)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction
  function automatic logic txr_of(input int d);
    case (d)
      0:       return txr0;
      1:       return txr1;
      default: return txr2;
    endcase
  endfunction
  // {MISO, tx_ready, busy}
  function automatic logic [2:0] status_of(input int d);
    case (d)
      0:       return {miso0, txr0, bsy0};
      1:       return {miso1, txr1, bsy1};
      default: return {miso2, txr2, bsy2};
    endcase
  endfunction
  // {rx_valid, tx_underrun, frame_abort}
  function automatic logic [2:0] pulses_of(input int d);
    case (d)
      0:       return {rxv0, und0, abt0};
      1:       return {rxv1, und1, abt1};
      default: return {rxv2, und2, abt2};
    endcase
  endfunction
  function automatic logic [31:0] rx_of(input int d);
    case (d)
      0:       return {24'h0, rxd0};
      1:       return {24'h0, rxd1};
      default: return {16'h0, rxd2};
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue a tx word through the valid/ready handshake and into the model.
  task automatic applyStimulus(input int d, input logic [31:0] word);
    @(negedge clk);
    case (d)
      0:       txd0 = word[7:0];
      1:       txd1 = word[7:0];
      default: txd2 = word[15:0];
    endcase
    txv[d] = 1'b1;
    @(negedge clk);
    txv[d] = 1'b0;
    mq_word[d] = word & mask_of(d);
    mq_full[d] = 1'b1;
  endtask

  // A load takes the queued word if there is one, otherwise IDLE_WORD.
  task automatic model_load(input int d, output logic [31:0] w);
    if (mq_full[d]) begin
      w = mq_word[d];
      mq_full[d] = 1'b0;
    end else begin
      w = idle_of(d);
      m_und[d]++;
    end
  endtask

  task automatic ss_low(input int d);
    ss[d] = 1'b0;
    wait_clk(H);
  endtask

  task automatic ss_high(input int d);
    wait_clk(H);
    ss[d] = 1'b1;
    wait_clk(H);
  endtask

  // Master side of nb bits; MISO is captured just before each sample edge.
  task automatic xfer(input int d, input logic [31:0] w, input int nb, output logic [31:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < nb; i++) begin
      idx = msb_of(d) ? (w_of(d) - 1 - i) : i;
      if (!cpha_of(d)) begin
        mosi[d] = w[idx];
        wait_clk(H);
        got[idx] = miso_of(d);
        sck[d] = ~sck[d];
        wait_clk(H);
        sck[d] = ~sck[d];
      end else begin
        sck[d] = ~sck[d];
        mosi[d] = w[idx];
        wait_clk(H);
        got[idx] = miso_of(d);
        sck[d] = ~sck[d];
        wait_clk(H);
      end
    end
  endtask

  task automatic snap(input int d);
    s_rxv  = rxv_n[d];
    s_und  = und_n[d];
    s_abt  = abt_n[d];
    s_mund = m_und[d];
  endtask

  // One frame of n words; lastbits>0 cuts the final word short. Loads occur
  // at selection, before every later word, and for CPHA=0 once more after
  // the final complete word.
  task automatic run_frame(input int d, input int n, input int lastbits);
    logic [31:0] tmp;
    ss_low(d);
    for (int k = 0; k < n; k++) begin
      model_load(d, em[k]);
      xfer(d, mw[k], (k == n - 1 && lastbits > 0) ? lastbits : w_of(d), gw[k]);
    end
    if (!cpha_of(d) && lastbits == 0) model_load(d, tmp);
    ss_high(d);
  endtask

  task automatic check_frame(input string tag, input int d, input int n, input bit full);
    int nfull;
    nfull = full ? n : n - 1;
    for (int k = 0; k < nfull; k++)
      checkOutput($sformatf("%s_miso_w%0d", tag, k), gw[k], em[k]);
    if (full) checkOutput({tag, "_rx_data"}, rx_of(d), mw[n-1] & mask_of(d));
    checkOutput({tag, "_rx_valid_n"}, 32'(rxv_n[d] - s_rxv), 32'(nfull));
    checkOutput({tag, "_underrun_n"}, 32'(und_n[d] - s_und), 32'(m_und[d] - s_mund));
    checkOutput({tag, "_abort_n"}, 32'(abt_n[d] - s_abt), full ? 32'd0 : 32'd1);
    checkOutput({tag, "_idle_status"}, {29'h0, status_of(d)}, 32'b010);
  endtask

  initial begin
    int d, n;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    sck = 3'b010;
    ss = 3'b111;
    mosi = 3'b000;
    txv = 3'b000;
    txd0 = '0;
    txd1 = '0;
    txd2 = '0;
    for (int i = 0; i < 3; i++) begin
      mq_word[i] = '0;
      mq_full[i] = 1'b0;
      m_und[i] = 0;
    end

    // Reset values, observed while rst is held.
    wait_clk(4);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_status%0d", i), {29'h0, status_of(i)}, 32'b010);
      checkOutput($sformatf("rst_pulses%0d", i), {29'h0, pulses_of(i)}, 32'b000);
      checkOutput($sformatf("rst_rx_data%0d", i), rx_of(i), 32'h0);
    end
    rst = 1'b0;
    wait_clk(4);

    // Mode 0: 0xA5 queued, master sends 0x3C.
    snap(0);
    applyStimulus(0, 32'hA5);
    mw[0] = 32'h3C;
    run_frame(0, 1, 0);
    checkOutput("t1_miso_bits", gw[0], 32'hA5);
    check_frame("t1", 0, 1, 1'b1);

    // Mode 3: 0x81 then 0x7E, tx_ready rising after each load.
    snap(1);
    applyStimulus(1, 32'h81);
    checkOutput("t2_ready_full0", {31'h0, txr_of(1)}, 32'h0);
    ss_low(1);
    model_load(1, em[0]);
    checkOutput("t2_ready_load0", {31'h0, txr_of(1)}, 32'h1);
    applyStimulus(1, 32'h7E);
    checkOutput("t2_ready_full1", {31'h0, txr_of(1)}, 32'h0);
    model_load(1, em[1]);
    mw[0] = $urandom & 32'hFF;
    mw[1] = $urandom & 32'hFF;
    xfer(1, mw[0], 8, gw[0]);
    checkOutput("t2_ready_held", {31'h0, txr_of(1)}, 32'h0);
    xfer(1, mw[1], 8, gw[1]);
    checkOutput("t2_ready_load1", {31'h0, txr_of(1)}, 32'h1);
    ss_high(1);
    checkOutput("t2_miso_w0", gw[0], 32'h81);
    checkOutput("t2_miso_w1", gw[1], 32'h7E);
    check_frame("t2", 1, 2, 1'b1);

    // Nothing queued, IDLE_WORD=0xFF: one underrun per word in mode 3.
    snap(1);
    mw[0] = $urandom & 32'hFF;
    mw[1] = $urandom & 32'hFF;
    run_frame(1, 2, 0);
    checkOutput("t3_underruns", 32'(und_n[1] - s_und), 32'd2);
    check_frame("t3", 1, 2, 1'b1);

    // SS released after 5 bits, then a clean frame.
    snap(0);
    mw[0] = $urandom & 32'hFF;
    run_frame(0, 1, 5);
    check_frame("t4_abort", 0, 1, 1'b0);
    snap(0);
    applyStimulus(0, $urandom);
    mw[0] = $urandom & 32'hFF;
    run_frame(0, 1, 0);
    check_frame("t4_next", 0, 1, 1'b1);

    // WIDTH=16, LSB first.
    snap(2);
    applyStimulus(2, $urandom);
    mw[0] = 32'h1234;
    run_frame(2, 1, 0);
    checkOutput("t5_rx_1234", rx_of(2), 32'h1234);
    check_frame("t5", 2, 1, 1'b1);

    // Randomised frames across all three configurations.
    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 2));
      snap(d);
      if ($urandom_range(0, 1) == 1) applyStimulus(d, $urandom);
      for (int k = 0; k < n; k++) mw[k] = $urandom & mask_of(d);
      run_frame(d, n, 0);
      check_frame($sformatf("rnd%0d_d%0d", it, d), d, n, 1'b1);
    end

    // Reset in the middle of a word.
    snap(0);
    applyStimulus(0, 32'h5A);
    mw[0] = $urandom & 32'hFF;
    ss_low(0);
    model_load(0, em[0]);
    xfer(0, mw[0], 3, gw[0]);
    wait_clk(2);
    rst = 1'b1;
    ss[0] = 1'b1;
    wait_clk(2);
    checkOutput("t6_status", {29'h0, status_of(0)}, 32'b010);
    checkOutput("t6_rx_data", rx_of(0), 32'h0);
    checkOutput("t6_pulses", {29'h0, pulses_of(0)}, 32'b000);
    for (int i = 0; i < 3; i++) mq_full[i] = 1'b0;
    rst = 1'b0;
    wait_clk(4);
    checkOutput("t6_no_rx_valid", 32'(rxv_n[0] - s_rxv), 32'd0);
    checkOutput("t6_no_abort", 32'(abt_n[0] - s_abt), 32'd0);
    snap(0);
    applyStimulus(0, $urandom);
    mw[0] = $urandom & 32'hFF;
    run_frame(0, 1, 0);
    check_frame("t6_next", 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_word_slave.md
SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH, 8, bits per SPI word (2..32)
  CPOL, 0, SCK idle level
  CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
  MSB_FIRST, 1, 1 = MSB first on MOSI and MISO, 0 = LSB first
  IDLE_WORD, 0, WIDTH-bit word sent when no tx word is queued
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  system clock; all logic is synchronous to its rising edge
  rst  input  1  asynchronous, active-high reset
  SCK  input  1  SPI clock from master, asynchronous to clk
  SS  input  1  active-low slave select, asynchronous
  MOSI  input  1  master-to-slave serial data, asynchronous
  MISO  output  1  slave-to-master serial data
  tx_data  input  WIDTH  word to transmit
  tx_valid  input  1  tx_data is valid
  tx_ready  output  1  holding register empty; accepts a word
  rx_data  output  WIDTH  last complete received word
  rx_valid  output  1  one-cycle pulse: rx_data updated
  tx_underrun  output  1  one-cycle pulse: IDLE_WORD loaded
  frame_abort  output  1  one-cycle pulse: SS released mid-word
  busy  output  1  synchronised SS is active

Function
REQ-003 SCK and SS SHALL pass through 3-flop shift-register synchronisers; edges SHALL be detected from bits [2:1]; MOSI SHALL use a 2-flop synchroniser, with bit [1] sampled.
REQ-004 The leading edge SHALL be the rising SCK edge if CPOL=0 and the falling edge if CPOL=1; the sample edge SHALL be the leading edge if CPHA=0 and the trailing edge otherwise; the other edge SHALL be the shift edge.
REQ-005 State machine SHALL have states IDLE and ACTIVE: IDLE->ACTIVE on synchronised SS falling edge; ACTIVE->IDLE on synchronised SS rising edge; SCK edges seen in IDLE SHALL be ignored.
REQ-006 A bit counter (0..WIDTH-1) SHALL increment on each sample edge in ACTIVE and wrap to 0 after WIDTH-1.
REQ-007 On each sample edge, the synchronised MOSI bit SHALL be shifted into the rx shift register in MSB_FIRST order.
REQ-008 On the sample edge of bit WIDTH-1, rx_data SHALL be loaded with the complete word, and rx_valid SHALL pulse high for exactly one clk on the following cycle.
REQ-009 A tx load event SHALL occur when: (a) IDLE->ACTIVE; (b) for CPHA=0, the first shift edge after the counter wraps; (c) for CPHA=1, the first shift edge of each word (counter = 0).
REQ-010 On a load event, the tx shift register SHALL take the holding register if it is full, emptying it; otherwise it SHALL take IDLE_WORD and pulse tx_underrun for one clk.
REQ-011 On every shift edge that is not a load event, the tx shift register SHALL shift by one in MSB_FIRST order.
REQ-012 MISO SHALL present the current first-order bit (MSB if MSB_FIRST) of the tx shift register while in ACTIVE, and 0 in IDLE.
REQ-013 tx_ready SHALL equal NOT holding-full; a word SHALL be accepted when tx_valid and tx_ready are both high at a clk edge.
REQ-014 If a handshake and a load event coincide while the holding register is empty, the load SHALL use IDLE_WORD (with underrun); the accepted word SHALL remain held for the next load.
REQ-015 If SS rises while the bit counter is nonzero, the partial rx word SHALL be discarded (no rx_valid), frame_abort SHALL pulse for one clk, and the counter SHALL clear; the holding register SHALL be kept.
REQ-016 busy SHALL be high exactly while the state is ACTIVE.

Reset
REQ-017 While rst is high, outputs SHALL be: MISO=0, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0, tx_ready=1; state SHALL be IDLE, counter 0, holding register empty.
REQ-018 While rst is high, the SCK synchroniser SHALL preset to CPOL, the SS synchroniser to 1, and MOSI to 0, so that release from reset creates no false edge.
REQ-019 Asserting rst mid-frame SHALL abort immediately without an rx_valid or frame_abort pulse.

Verification
REQ-020 Bench SHALL cover, as directed tests:
  WIDTH=8, mode 0, tx 0xA5 queued, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
  Mode 3, two back-to-back words with 0x81 and 0x7E queued -> MISO bits 0x81 then 0x7E; tx_ready rises after each load.
  No tx word queued, IDLE_WORD=0xFF -> MISO all ones; one tx_underrun pulse per word.
  SS released after 5 bits -> no rx_valid; frame_abort pulses once; next frame rx_data is correct.
  WIDTH=16, MSB_FIRST=0, master sends 0x1234 -> rx_data=0x1234.
  rst asserted mid-word -> all outputs at reset values; subsequent frame is correct.
